// File: rtl/sa_feed_ctrl_pkg.sv
// sa_feed_ctrl_pkg: shared types and default sizing for the systolic array feed controller.
package sa_feed_ctrl_pkg;
  localparam int SA_N = 4;
  localparam int SA_DW = 16;
  localparam int SA_DRAIN = SA_N + 1;
  localparam int CNT_W = 8;
  function automatic int feed_cycles(input int n);
    return 2 * n - 1;
  endfunction
  localparam int FEED_CYCLES = feed_cycles(SA_N);
  localparam int IDX_W = $clog2(SA_N * SA_N);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_t;
endpackage

// File: rtl/sa_skew_mux.sv
// sa_skew_mux: diagonal-skewed west/north operand selection for feed step t.
module sa_skew_mux
  import sa_feed_ctrl_pkg::*;
#(
  parameter int N = SA_N,
  parameter int DW = SA_DW
) (
  input  logic [CNT_W-1:0]    i_t,
  input  logic [N*N*DW-1:0]   i_a,
  input  logic [N*N*DW-1:0]   i_b,
  output logic [N*DW-1:0]     o_west,
  output logic [N*DW-1:0]     o_north
);
  always_comb begin
    o_west = '0;
    o_north = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(i_t) - i;
      if (d >= 0 && d < N) begin
        o_west[i*DW +: DW] = i_a[(i*N + d)*DW +: DW];
        o_north[i*DW +: DW] = i_b[(d*N + i)*DW +: DW];
      end
    end
  end
endmodule

// File: rtl/sa_feed_ctrl.sv
// sa_feed_ctrl: operand buffers, feed sequencing and result capture for the NxN systolic array.
module sa_feed_ctrl
  import sa_feed_ctrl_pkg::*;
#(
  parameter int N = SA_N,
  parameter int DW = SA_DW,
  parameter int DRAIN_CYCLES = SA_DRAIN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic               wr_err,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  output logic               array_clr,
  output logic [N*DW-1:0]    west_o,
  output logic [N*DW-1:0]    north_o,
  input  logic [N*N*DW-1:0]  res_in,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [DW-1:0]      rd_data
);
  localparam int NN = N * N;
  localparam int FC = feed_cycles(N);
  state_t r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_t;
  logic [NN*DW-1:0] r_a, r_b, r_res;
  logic [N*DW-1:0] r_west, r_north, w_west, w_north;
  logic r_res_valid, r_wr_err, w_wr;
  assign w_wr = wr_en && r_state == IDLE && int'(wr_addr) < NN;
  // feed step presented on the edge entering the next FEED cycle
  assign w_t = (r_state == FEED) ? r_cnt + CNT_W'(1) : '0;
  sa_skew_mux #(.N(N), .DW(DW)) u_skew (
    .i_t(w_t),
    .i_a(r_a),
    .i_b(r_b),
    .o_west(w_west),
    .o_north(w_north)
  );
  always_ff @(posedge clk) r_state <= !rst ? IDLE : w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = start ? CLEAR : IDLE;
      CLEAR:   w_nxt = FEED;
      FEED:    w_nxt = (r_cnt == CNT_W'(FC - 1)) ? DRAIN : FEED;
      DRAIN:   w_nxt = (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) ? CAPTURE : DRAIN;
      CAPTURE: w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
    array_clr = r_state == CLEAR;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_west <= '0;
      r_north <= '0;
      r_res_valid <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_cnt <= (w_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (w_wr && !wr_sel) r_a[int'(wr_addr)*DW +: DW] <= wr_data;
      if (w_wr && wr_sel) r_b[int'(wr_addr)*DW +: DW] <= wr_data;
      if (r_state == CAPTURE) r_res <= res_in;
      r_west <= (w_nxt == FEED) ? w_west : '0;
      r_north <= (w_nxt == FEED) ? w_north : '0;
      r_res_valid <= (r_state == CAPTURE) || (r_res_valid && !(r_state == IDLE && start));
      r_wr_err <= r_wr_err || (wr_en && r_state != IDLE);
    end
  end
  assign west_o = r_west;
  assign north_o = r_north;
  assign res_valid = r_res_valid;
  assign wr_err = r_wr_err;
  assign rd_data = (int'(rd_addr) < NN) ? r_res[int'(rd_addr)*DW +: DW] : '0;
endmodule
